// File: rtl/p_sub_sched.sv
// Round-robin scheduler sharing one saturating subtractor among REQ_N
// requesters, with a one-entry result slot and valid/ready handshakes.
//
// Ports: clk, reset_ (async, active low), flush (drops the held result).
//   Request side:  req_valid, req_ready, req_in1, req_in2.
//   Packing:       requester i sits in bits [i*PREC +: PREC].
//   Response side: resp_valid, resp_ready, resp_id, resp_out, resp_ovf.
//   Status:        busy (equals resp_valid).
//   ovf_cnt:       16-bit saturation event count, present only when
//                  P_SUB_STAT_EN is defined.
module p_sub_sched #(
  parameter int REQ_N = 4,
  parameter int PREC  = 8,
  parameter int ID_W  = $clog2(REQ_N)
) (
  input  logic                  clk,
  input  logic                  reset_,
  input  logic                  flush,
  input  logic [REQ_N-1:0]      req_valid,
  output logic [REQ_N-1:0]      req_ready,
  input  logic [REQ_N*PREC-1:0] req_in1,
  input  logic [REQ_N*PREC-1:0] req_in2,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [ID_W-1:0]       resp_id,
  output logic [PREC-1:0]       resp_out,
  output logic                  resp_ovf,
  output logic                  busy
`ifdef P_SUB_STAT_EN
  ,
  output logic [15:0]           ovf_cnt
`endif
);

  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] gnt;
  logic            found;
  logic            slot_free;
  logic            xfer;
  logic [PREC-1:0] op_a [REQ_N];
  logic [PREC-1:0] op_b [REQ_N];
  logic [PREC:0]   diff;
  logic [PREC-1:0] sub_out;
  logic            sub_ovf;
  logic [ID_W-1:0] rr_next;

  for (genvar i = 0; i < REQ_N; i++) begin : g_unpack
    assign op_a[i] = req_in1[i*PREC +: PREC];
    assign op_b[i] = req_in2[i*PREC +: PREC];
  end

  // Scan from rr_ptr upward, wrapping at REQ_N; first valid wins.
  always_comb begin
    logic [ID_W:0] s;
    s     = '0;
    found = 1'b0;
    gnt   = '0;
    for (int k = 0; k < REQ_N; k++) begin
      s = {1'b0, rr_ptr} + (ID_W+1)'(k);
      if (s >= (ID_W+1)'(REQ_N)) begin
        s = s - (ID_W+1)'(REQ_N);
      end
      if (!found && req_valid[s[ID_W-1:0]]) begin
        found = 1'b1;
        gnt   = s[ID_W-1:0];
      end
    end
  end

  assign slot_free = !resp_valid || resp_ready;
  assign xfer      = found && slot_free && !flush;

  always_comb begin
    req_ready = '0;
    if (xfer) begin
      req_ready[gnt] = 1'b1;
    end
  end

  // One extra bit catches overflow: top two bits disagree.
  always_comb begin
    diff = {op_a[gnt][PREC-1], op_a[gnt]}
         - {op_b[gnt][PREC-1], op_b[gnt]};
    sub_ovf = diff[PREC] != diff[PREC-1];
    sub_out = diff[PREC-1:0];
    if (sub_ovf) begin
      sub_out = diff[PREC] ? {1'b1, {(PREC-1){1'b0}}}
                           : {1'b0, {(PREC-1){1'b1}}};
    end
  end

  assign rr_next = (gnt == ID_W'(REQ_N-1)) ? '0 : gnt + 1'b1;

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      resp_valid <= 1'b0;
      resp_out   <= '0;
      resp_ovf   <= 1'b0;
      resp_id    <= '0;
      rr_ptr     <= '0;
    end else if (xfer) begin
      resp_valid <= 1'b1;
      resp_out   <= sub_out;
      resp_ovf   <= sub_ovf;
      resp_id    <= gnt;
      rr_ptr     <= rr_next;
    end else if (flush || resp_ready) begin
      resp_valid <= 1'b0;
    end
  end

`ifdef P_SUB_STAT_EN
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      ovf_cnt <= '0;
    end else if (xfer && sub_ovf && ovf_cnt != 16'hFFFF) begin
      ovf_cnt <= ovf_cnt + 16'd1;
    end
  end
`endif

  assign busy = resp_valid;

endmodule

// File: tb/tb_p_sub_sched.sv
// Self-checking bench for p_sub_sched: directed scenarios plus random
// traffic against an arithmetic reference model.
module tb_p_sub_sched;
  localparam int N = 4;
  localparam int P = 8;
  localparam int W = 2;

  logic           clk = 1'b0;
  logic           reset_;
  logic           flush;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*P-1:0] req_in1;
  logic [N*P-1:0] req_in2;
  logic           resp_valid;
  logic           resp_ready;
  logic [W-1:0]   resp_id;
  logic [P-1:0]   resp_out;
  logic           resp_ovf;
  logic           busy;
`ifdef P_SUB_STAT_EN
  logic [15:0]    ovf_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  bit         m_valid;
  logic [P-1:0] m_out;
  bit         m_ovf;
  int         m_id;
  int         m_rr;
  int         m_cnt;

  p_sub_sched #(.REQ_N(N), .PREC(P), .ID_W(W)) dut (
    .clk(clk), .reset_(reset_), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_in1(req_in1), .req_in2(req_in2),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_out(resp_out),
    .resp_ovf(resp_ovf), .busy(busy)
`ifdef P_SUB_STAT_EN
    , .ovf_cnt(ovf_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic int opnd(logic [N*P-1:0] v, int i);
    logic [P-1:0] x;
    x = v[i*P +: P];
    return int'($signed(x));
  endfunction

  function automatic int sat(int a, int b, output bit o);
    int d;
    int mx;
    int mn;
    d  = a - b;
    mx = (1 << (P-1)) - 1;
    mn = -(1 << (P-1));
    o  = 1'b0;
    if (d > mx) begin
      d = mx;
      o = 1'b1;
    end else if (d < mn) begin
      d = mn;
      o = 1'b1;
    end
    return d;
  endfunction

  function automatic int exp_grant();
    if (flush || (m_valid && !resp_ready)) return -1;
    for (int k = 0; k < N; k++) begin
      if (req_valid[(m_rr + k) % N]) return (m_rr + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_ready();
    logic [N-1:0] r;
    int g;
    r = '0;
    g = exp_grant();
    if (g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  task automatic model_reset();
    m_valid = 0;
    m_out   = '0;
    m_ovf   = 0;
    m_id    = 0;
    m_rr    = 0;
    m_cnt   = 0;
  endtask

  task automatic model_edge();
    int g;
    int d;
    bit o;
    g = exp_grant();
    if (g >= 0) begin
      d       = sat(opnd(req_in1, g), opnd(req_in2, g), o);
      m_out   = d[P-1:0];
      m_ovf   = o;
      m_id    = g;
      m_valid = 1;
      m_rr    = (g + 1) % N;
      if (o && m_cnt < 65535) m_cnt++;
    end else if (flush || (m_valid && resp_ready)) begin
      m_valid = 0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_op(int i, int a, int b);
    req_in1[i*P +: P] = P'(a);
    req_in2[i*P +: P] = P'(b);
  endtask

  task automatic do_reset();
    reset_     = 1'b0;
    flush      = 1'b0;
    req_valid  = '0;
    resp_ready = 1'b0;
    req_in1    = '0;
    req_in2    = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset_ = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    reset_    = 1'b0;
    req_valid = '0;
    flush     = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (resp_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_valid: got %b/%b want 0/0", resp_valid, busy);
    end
    n_checks++;
    if (resp_out !== '0 || resp_ovf !== 1'b0 || resp_id !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got %h/%b/%0d want 0/0/0",
               resp_out, resp_ovf, resp_id);
    end
    n_checks++;
    if (req_ready !== '0) begin
      n_fail++;
      $display("FAIL reset_ready: got %b want 0000", req_ready);
    end
`ifdef P_SUB_STAT_EN
    n_checks++;
    if (ovf_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_cnt: got %0d want 0", ovf_cnt);
    end
`endif
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    resp_ready = 1'b1;
    req_valid  = 4'b0100;
    set_op(2, 100, -50);
    #1;
    n_checks++;
    if (req_ready !== 4'b0100) begin
      n_fail++;
      $display("FAIL single_ready: got %b want 0100", req_ready);
    end
    step();
    req_valid = '0;
    n_checks++;
    if (resp_valid !== 1'b1 || resp_id !== 2'd2 ||
        resp_out !== 8'd127 || resp_ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL single_resp: got v%b id%0d out%0d ovf%b want v1 id2 out127 ovf1",
               resp_valid, resp_id, $signed(resp_out), resp_ovf);
    end
  endtask

  task automatic test_arith();
    int a [6] = '{-128, -128, 5, 127, -1, 0};
    int b [6] = '{1, -128, 7, -128, 127, -128};
    int eo[6] = '{-128, 0, -2, 127, -128, 127};
    bit ev[6] = '{1, 0, 0, 1, 0, 1};
    do_reset();
    resp_ready = 1'b1;
    req_valid  = 4'b0001;
    for (int i = 0; i < 6; i++) begin
      set_op(0, a[i], b[i]);
      step();
      n_checks++;
      if (resp_valid !== 1'b1 || $signed(resp_out) !== 8'(eo[i]) ||
          resp_ovf !== ev[i]) begin
        n_fail++;
        $display("FAIL arith_%0d: got v%b out%0d ovf%b want v1 out%0d ovf%b",
                 i, resp_valid, $signed(resp_out), resp_ovf, eo[i], ev[i]);
      end
    end
    req_valid = '0;
  endtask

  task automatic test_round_robin();
    int e;
    do_reset();
    resp_ready = 1'b1;
    req_valid  = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      e = i % N;
      for (int j = 0; j < N; j++) set_op(j, $urandom_range(255), $urandom_range(255));
      #1;
      n_checks++;
      if (req_ready !== 4'(1 << e)) begin
        n_fail++;
        $display("FAIL rr_ready_%0d: got %b want %b", i, req_ready, 4'(1 << e));
      end
      step();
      n_checks++;
      if (resp_valid !== 1'b1 || resp_id !== 2'(e) || resp_out !== m_out) begin
        n_fail++;
        $display("FAIL rr_resp_%0d: got v%b id%0d out%h want v1 id%0d out%h",
                 i, resp_valid, resp_id, resp_out, e, m_out);
      end
    end
    req_valid = '0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    req_valid = 4'b1111;
    set_op(0, 10, 3);
    set_op(1, -20, 30);
    step();
    resp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (req_ready !== '0) begin
        n_fail++;
        $display("FAIL stall_ready_%0d: got %b want 0000", i, req_ready);
      end
      step();
      n_checks++;
      if (resp_valid !== 1'b1 || resp_id !== 2'd0 ||
          resp_out !== 8'd7 || resp_ovf !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_hold_%0d: got v%b id%0d out%0d want v1 id0 out7",
                 i, resp_valid, resp_id, resp_out);
      end
    end
    resp_ready = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 4'b0010) begin
      n_fail++;
      $display("FAIL drain_ready: got %b want 0010", req_ready);
    end
    step();
    n_checks++;
    if (resp_valid !== 1'b1 || resp_id !== 2'd1 || $signed(resp_out) !== -8'sd50) begin
      n_fail++;
      $display("FAIL drain_reload: got v%b id%0d out%0d want v1 id1 out-50",
               resp_valid, resp_id, $signed(resp_out));
    end
    req_valid = '0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    resp_ready = 1'b1;
    req_valid  = 4'b1111;
    step();
    step();
    reset_ = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (resp_valid !== 1'b0 || resp_id !== '0) begin
      n_fail++;
      $display("FAIL midreset_clear: got v%b id%0d want v0 id0", resp_valid, resp_id);
    end
    req_valid = 4'b1010;
    @(posedge clk);
    #1 reset_ = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 4'b0010) begin
      n_fail++;
      $display("FAIL midreset_ready: got %b want 0010", req_ready);
    end
    step();
    n_checks++;
    if (resp_valid !== 1'b1 || resp_id !== 2'd1) begin
      n_fail++;
      $display("FAIL midreset_grant: got v%b id%0d want v1 id1", resp_valid, resp_id);
    end
    req_valid = '0;
  endtask

  task automatic test_flush();
    do_reset();
    req_valid = 4'b0001;
    step();
    flush      = 1'b1;
    resp_ready = 1'b1;
    req_valid  = 4'b1111;
    #1;
    n_checks++;
    if (req_ready !== '0) begin
      n_fail++;
      $display("FAIL flush_ready: got %b want 0000", req_ready);
    end
    step();
    flush = 1'b0;
    n_checks++;
    if (resp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_clear: got %b want 0", resp_valid);
    end
    #1;
    n_checks++;
    if (req_ready !== 4'b0010) begin
      n_fail++;
      $display("FAIL flush_ptr: got %b want 0010", req_ready);
    end
    req_valid = '0;
  endtask

  task automatic test_random();
    logic [N-1:0] er;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      req_valid  = N'($urandom);
      resp_ready = ($urandom_range(3) != 0);
      flush      = ($urandom_range(15) == 0);
      req_in1    = {$urandom, $urandom};
      req_in2    = {$urandom, $urandom};
      #1;
      er = exp_ready();
      n_checks++;
      if (req_ready !== er) begin
        n_fail++;
        $display("FAIL rand_ready_%0d: got %b want %b", c, req_ready, er);
      end
      step();
      n_checks++;
      if (resp_valid !== m_valid || busy !== m_valid ||
          (m_valid && (resp_out !== m_out || resp_ovf !== m_ovf ||
                       resp_id !== 2'(m_id)))) begin
        n_fail++;
        $display("FAIL rand_resp_%0d: got v%b out%h ovf%b id%0d want v%b out%h ovf%b id%0d",
                 c, resp_valid, resp_out, resp_ovf, resp_id,
                 m_valid, m_out, m_ovf, m_id);
      end
`ifdef P_SUB_STAT_EN
      n_checks++;
      if (ovf_cnt !== 16'(m_cnt)) begin
        n_fail++;
        $display("FAIL rand_cnt_%0d: got %0d want %0d", c, ovf_cnt, m_cnt);
      end
`endif
    end
    flush     = 1'b0;
    req_valid = '0;
  endtask

`ifdef P_SUB_STAT_EN
  task automatic test_stat();
    do_reset();
    resp_ready = 1'b1;
    req_valid  = 4'b0001;
    set_op(0, 127, -1);
    repeat (3) step();
    n_checks++;
    if (ovf_cnt !== 16'd3) begin
      n_fail++;
      $display("FAIL stat_three: got %0d want 3", ovf_cnt);
    end
    repeat (65530) step();
    n_checks++;
    if (ovf_cnt !== 16'hFFFD) begin
      n_fail++;
      $display("FAIL stat_near: got %h want fffd", ovf_cnt);
    end
    repeat (4) step();
    n_checks++;
    if (ovf_cnt !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL stat_sat: got %h want ffff", ovf_cnt);
    end
    req_valid = '0;
  endtask
`endif

  initial begin
    reset_     = 1'b0;
    flush      = 1'b0;
    req_valid  = '0;
    resp_ready = 1'b0;
    req_in1    = '0;
    req_in2    = '0;
    test_reset();
    test_single();
    test_arith();
    test_round_robin();
    test_back_to_back();
    test_reset_mid();
    test_flush();
    test_random();
`ifdef P_SUB_STAT_EN
    test_stat();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/p_sub_sched.md
P_SUB_SCHED -- requirements
Module: p_sub_sched

Interface
REQ-001 SHALL have parameter REQ_N, default 4: number of requesters sharing the subtractor, 2..8.
REQ-002 SHALL have parameter PREC, default 8: operand and result precision in bits, signed two's complement, 2..32.
REQ-003 SHALL have parameter ID_W, default $clog2(REQ_N): requester-index width.
REQ-004 SHALL have ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset_  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous discard of the held result.
- req_valid  input  REQ_N  per-requester operation request.
- req_ready  output  REQ_N  per-requester acceptance (one-hot or zero).
- req_in1  input  REQ_N*PREC  minuends; requester i in bits [i*PREC +: PREC].
- req_in2  input  REQ_N*PREC  subtrahends, same packing.
- resp_valid  output  1  result held.
- resp_ready  input  1  consumer accepts result.
- resp_id  output  ID_W  index of the requester that owns the result.
- resp_out  output  PREC  saturated difference.
- resp_ovf  output  1  saturation occurred.
- busy  output  1  equals resp_valid.
- ovf_cnt  output  16  saturation event count (present only with P_SUB_STAT_EN).

Function
REQ-005 SHALL contain one shared saturating subtractor plus a one-entry output register (slot).
REQ-006 SHALL treat the slot as free when resp_valid=0 or (resp_valid=1 and resp_ready=1); otherwise it is full.
REQ-007 SHALL grant at most one requester per cycle, only when the slot is free and flush=0; the grant is req_ready[g]=1, and a transfer occurs when req_valid[g]=1 in the same cycle.
REQ-008 SHALL select g round-robin: the first i with req_valid[i]=1, searching from the pointer rr_ptr upward and wrapping from REQ_N-1 to 0.
REQ-009 SHALL set rr_ptr to (g+1) mod REQ_N after each transfer; rr_ptr SHALL hold when no transfer occurs.
REQ-010 SHALL drive req_ready combinationally from req_valid, rr_ptr and slot state; req_ready SHALL be all-zero when no request is pending or the slot is full.
REQ-011 SHALL compute the difference at PREC+1 bits as sign-extended in1 minus sign-extended in2.
- If the result is above 2^(PREC-1)-1: out=2^(PREC-1)-1, ovf=1.
- If the result is below -2^(PREC-1): out=-2^(PREC-1), ovf=1.
- Otherwise: out=the low PREC bits, ovf=0.
REQ-012 SHALL load resp_out, resp_ovf and resp_id=g on the transfer edge; resp_valid=1 SHALL be visible on the next cycle (latency 1).
REQ-013 SHALL hold resp_out, resp_ovf and resp_id stable while resp_valid=1 and resp_ready=0.
REQ-014 SHALL clear resp_valid on a drain (resp_valid=1 and resp_ready=1) with no simultaneous transfer; a drain and a transfer in the same cycle SHALL reload the slot without a bubble, so sustained throughput is 1 op/cycle.
REQ-015 SHALL, on flush=1, clear resp_valid on the next edge, block all grants that cycle, and leave rr_ptr and ovf_cnt unchanged.

Reset
REQ-016 SHALL, while reset_=0, asynchronously force resp_valid=0, resp_out=0, resp_ovf=0, resp_id=0, rr_ptr=0 and ovf_cnt=0.
REQ-017 SHALL drop any operation in flight when reset is asserted mid-operation; after release, the first grant SHALL search from index 0.

Configuration
REQ-018 SHALL, with macro P_SUB_STAT_EN defined, provide port ovf_cnt: +1 on each transfer whose computed ovf=1, saturating at 16'hFFFF (no wrap).
REQ-019 SHALL, without P_SUB_STAT_EN, omit the ovf_cnt port and its counter logic; all other behaviour SHALL be identical.

Verification
REQ-020 SHALL cover these directed scenarios (PREC=8, REQ_N=4):
- Only req_valid[2], in1=100, in2=-50 -> req_ready=4'b0100; next cycle resp_valid=1, resp_id=2, resp_out=127, resp_ovf=1.
- All four req_valid held high, resp_ready=1 -> grant order 0,1,2,3,0, one per cycle, resp_valid continuously 1.
- resp_ready=0 for 3 cycles while full -> req_ready=0 and resp_* stable; on release, same-cycle drain+reload with no bubble.
- in1=-128, in2=1 -> out=-128, ovf=1; in1=-128, in2=-128 -> out=0, ovf=0; in1=5, in2=7 -> out=-2, ovf=0.
- reset_ low mid-stream with rr_ptr=2 -> resp_valid=0 at once; after release, first grant goes to the lowest valid index from 0. Flush with a result held -> resp_valid=0 next cycle, no grant that cycle.
- P_SUB_STAT_EN defined, 3 saturating ops -> ovf_cnt=3; preload near max -> holds at 16'hFFFF.
